// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller.
//   state_t      : controller FSM states (IDLE, VEND, CHANGE)
//   COIN_*       : coin_type encodings from the coin acceptor
//   coin_value() : maps a coin_type to its worth in 5-cent units (0 for illegal)
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [1:0] COIN_5C      = 2'b00;
  localparam logic [1:0] COIN_10C     = 2'b01;
  localparam logic [1:0] COIN_25C     = 2'b10;
  localparam logic [1:0] COIN_ILLEGAL = 2'b11;

  function automatic logic [2:0] coin_value(input logic [1:0] ct);
    case (ct)
      COIN_5C:  return 3'd1;
      COIN_10C: return 3'd2;
      COIN_25C: return 3'd5;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters for the vending controller.
// Every counter resets to full (2**STOCK_W-1).
// Ports:
//   clk, rst  : clock, async active-high reset
//   dec       : decrement stock[id] by one (never below zero)
//   refill    : restore stock[id] to full; wins over dec for the same item
//   id        : item index for dec/refill; indices >= N_ITEMS are ignored
//   sold_out  : bit i set when stock[i] == 0
module vend_stock
  import vend_pkg::*;
#(
  parameter int N_ITEMS = 4,
  parameter int STOCK_W = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec,
  input  logic               refill,
  input  logic [ID_W-1:0]    id,
  output logic [N_ITEMS-1:0] sold_out
);

  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  logic [STOCK_W-1:0] stock [N_ITEMS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock[i] <= STOCK_MAX;
      end
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (id == ID_W'(i)) begin
          if (refill) begin
            stock[i] <= STOCK_MAX;
          end else if (dec && (stock[i] != '0)) begin
            stock[i] <= stock[i] - 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_sold
    assign sold_out[g] = (stock[g] == '0);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Multi-item vending controller: accumulates coin credit, sells one of
// N_ITEMS products at a common PRICE and tracks per-item stock.
// Optional feature macro: VEND_CHANGE_EN (adds the CHANGE state, change
// return after a vend and cancel/refund). Without it, leftover credit is
// carried into the next purchase and cancel is ignored.
// Ports:
//   clk, rst            : clock, async active-high reset
//   coin_valid/coin_type: one-cycle coin strobe and its type
//   sel_valid/sel_id    : one-cycle product select and index
//   cancel              : one-cycle refund request
//   refill              : restore stock[sel_id] to full (IDLE only)
//   coin_reject         : pulse, coin returned uncredited
//   vend_valid/vend_id  : pulse, dispense vend_id
//   credit              : current credit (registered)
//   change_valid/amt    : pulse, return change_amt units
//   sold_out            : bit i set when item i is empty
module vend_ctrl
  import vend_pkg::*;
#(
  parameter  int PRICE    = 3,
  parameter  int N_ITEMS  = 4,
  parameter  int STOCK_W  = 4,
  parameter  int CREDIT_W = 5,
  localparam int ID_W     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  input  logic                cancel,
  input  logic                refill,
  output logic                coin_reject,
  output logic                vend_valid,
  output logic [ID_W-1:0]     vend_id,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [N_ITEMS-1:0]  sold_out
);

  state_t              state;
  logic                in_idle;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_legal;
  logic                coin_ok;
  logic                sel_in_range;
  logic                sel_ok;
  logic                cancel_ok;
  logic                stock_refill;

  assign in_idle = (state == IDLE);

  // One extra bit so an overflowing sum is seen in the MSB rather than wrapping.
  assign coin_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_type));
  assign coin_legal = (coin_type != COIN_ILLEGAL) && !coin_sum[CREDIT_W];

  // Only a non-power-of-two item count can produce an out-of-range index.
  if (N_ITEMS == (1 << ID_W)) begin : g_full_range
    assign sel_in_range = 1'b1;
  end else begin : g_part_range
    assign sel_in_range = ({1'b0, sel_id} < (ID_W+1)'(N_ITEMS));
  end

`ifdef VEND_CHANGE_EN
  assign cancel_ok = in_idle && cancel && (credit != '0);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_ok     = 1'b0;
`endif

  // refill and an accepted cancel both take precedence over a purchase.
  assign sel_ok = in_idle && sel_valid && !refill && !cancel_ok && sel_in_range &&
                  (credit >= CREDIT_W'(PRICE)) && !sold_out[sel_id];

  // A coin is only credited when nothing else claims the credit register.
  assign coin_ok      = in_idle && coin_valid && coin_legal && !sel_ok && !cancel_ok;
  assign stock_refill = in_idle && refill;

  vend_stock #(
    .N_ITEMS (N_ITEMS),
    .STOCK_W (STOCK_W),
    .ID_W    (ID_W)
  ) u_stock (
    .clk      (clk),
    .rst      (rst),
    .dec      (sel_ok),
    .refill   (stock_refill),
    .id       (sel_id),
    .sold_out (sold_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      coin_reject  <= 1'b0;
      vend_valid   <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
    end else begin
      coin_reject  <= coin_valid && !coin_ok;
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel_ok) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
          end else if (sel_ok) begin
            state      <= VEND;
            vend_valid <= 1'b1;
            vend_id    <= sel_id;
            credit     <= credit - CREDIT_W'(PRICE);
          end else if (coin_ok) begin
            credit <= coin_sum[CREDIT_W-1:0];
          end
        end
        VEND: begin
`ifdef VEND_CHANGE_EN
          if (credit != '0) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        CHANGE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       refill = 1'b0;
  logic       coin_reject;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic [4:0] credit;
  logic       change_valid;
  logic [4:0] change_amt;
  logic [3:0] sold_out;

  int n_cmp = 0;
  int n_bad = 0;

  vend_ctrl #(.PRICE(3), .N_ITEMS(4), .STOCK_W(4), .CREDIT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .refill       (refill),
    .coin_reject  (coin_reject),
    .vend_valid   (vend_valid),
    .vend_id      (vend_id),
    .credit       (credit),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .sold_out     (sold_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for exactly one rising edge, then sample 1 time unit later.
  task automatic drive(input logic cv, input logic [1:0] ct, input logic sv,
                       input logic [1:0] sid, input logic cn, input logic rf);
    coin_valid = cv; coin_type = ct; sel_valid = sv; sel_id = sid;
    cancel = cn; refill = rf;
    @(posedge clk); #1;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; refill = 1'b0;
  endtask

  task automatic coin(input logic [1:0] ct);
    drive(1'b1, ct, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic sel(input logic [1:0] id);
    drive(1'b0, 2'b00, 1'b1, id, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // ---- Reset state
    do_reset();
    check("rst_credit", int'(credit), 0);
    check("rst_vend_valid", int'(vend_valid), 0);
    check("rst_vend_id", int'(vend_id), 0);
    check("rst_coin_reject", int'(coin_reject), 0);
    check("rst_change_valid", int'(change_valid), 0);
    check("rst_change_amt", int'(change_amt), 0);
    check("rst_sold_out", int'(sold_out), 0);

    // ---- 1) 5c + 10c, buy item 0
    coin(2'b00);
    check("t1_credit_1", int'(credit), 1);
    coin(2'b01);
    check("t1_credit_3", int'(credit), 3);
    sel(2'd0);
    check("t1_vend_valid", int'(vend_valid), 1);
    check("t1_vend_id", int'(vend_id), 0);
    check("t1_credit_0", int'(credit), 0);
    check("t1_stock0", int'(dut.u_stock.stock[0]), 14);
    idle();
    check("t1_vend_pulse_end", int'(vend_valid), 0);
    check("t1_no_change", int'(change_valid), 0);

    // ---- 2) Overflow and illegal coin rejection
    do_reset();
    for (int i = 0; i < 6; i++) coin(2'b10);
    check("t2_credit_30", int'(credit), 30);
    coin(2'b10);
    check("t2_ovf_reject", int'(coin_reject), 1);
    check("t2_ovf_credit", int'(credit), 30);
    coin(2'b11);
    check("t2_illegal_reject", int'(coin_reject), 1);
    check("t2_illegal_credit", int'(credit), 30);
    coin(2'b00);
    check("t2_max_accept", int'(coin_reject), 0);
    check("t2_credit_31", int'(credit), 31);

    // ---- 3) Insufficient credit, vend with leftover, coin during VEND
    do_reset();
    coin(2'b01);
    sel(2'd1);
    check("t3_low_no_vend", int'(vend_valid), 0);
    check("t3_low_credit", int'(credit), 2);
    coin(2'b01);
    coin(2'b00);
    check("t3_credit_5", int'(credit), 5);
    sel(2'd1);
    check("t3_vend_valid", int'(vend_valid), 1);
    check("t3_vend_id", int'(vend_id), 1);
    check("t3_credit_after", int'(credit), 2);
    coin(2'b00);
    check("t3_vend_coin_reject", int'(coin_reject), 1);
`ifdef VEND_CHANGE_EN
    check("t3_change_valid", int'(change_valid), 1);
    check("t3_change_amt", int'(change_amt), 2);
    check("t3_change_credit", int'(credit), 0);
`else
    check("t3_change_valid", int'(change_valid), 0);
    check("t3_change_amt", int'(change_amt), 0);
    check("t3_carry_credit", int'(credit), 2);
`endif
    idle();

    // ---- 4) Drain item 2, sold-out, refill priority
    do_reset();
    for (int i = 0; i < 15; i++) begin
      coin(2'b01);
      coin(2'b00);
      sel(2'd2);
      check("t4_drain_vend", int'(vend_valid), 1);
      idle();
    end
    check("t4_sold_out", int'(sold_out), 4'b0100);
    coin(2'b01);
    coin(2'b00);
    sel(2'd2);
    check("t4_empty_no_vend", int'(vend_valid), 0);
    check("t4_empty_credit", int'(credit), 3);
    drive(1'b0, 2'b00, 1'b1, 2'd2, 1'b0, 1'b1);
    check("t4_refill_no_vend", int'(vend_valid), 0);
    check("t4_refill_sold_out", int'(sold_out), 0);
    check("t4_refill_credit", int'(credit), 3);
    sel(2'd2);
    check("t4_post_refill_vend", int'(vend_valid), 1);
    check("t4_post_refill_id", int'(vend_id), 2);
    idle();

    // ---- 5) Coin + select same cycle, cancel
    do_reset();
    coin(2'b01);
    coin(2'b00);
    drive(1'b1, 2'b10, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t5_same_vend", int'(vend_valid), 1);
    check("t5_same_reject", int'(coin_reject), 1);
    check("t5_same_credit", int'(credit), 0);
    idle();
    drive(1'b1, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t5_rejsel_no_vend", int'(vend_valid), 0);
    check("t5_rejsel_coin_ok", int'(coin_reject), 0);
    check("t5_rejsel_credit", int'(credit), 1);
    coin(2'b00);
    coin(2'b01);
    check("t5_credit_4", int'(credit), 4);
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
`ifdef VEND_CHANGE_EN
    check("t5_cancel_valid", int'(change_valid), 1);
    check("t5_cancel_amt", int'(change_amt), 4);
    check("t5_cancel_credit", int'(credit), 0);
`else
    check("t5_cancel_valid", int'(change_valid), 0);
    check("t5_cancel_amt", int'(change_amt), 0);
    check("t5_cancel_credit", int'(credit), 4);
`endif
    idle();

    // ---- 6) Reset during VEND
    do_reset();
    coin(2'b10);
    sel(2'd3);
    check("t6_vend_valid", int'(vend_valid), 1);
    check("t6_stock3_dec", int'(dut.u_stock.stock[3]), 14);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_credit", int'(credit), 0);
    check("t6_rst_vend_valid", int'(vend_valid), 0);
    check("t6_rst_coin_reject", int'(coin_reject), 0);
    check("t6_rst_change_valid", int'(change_valid), 0);
    check("t6_rst_stock3", int'(dut.u_stock.stock[3]), 15);
    rst = 1'b0;
    idle();
    check("t6_post_credit", int'(credit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
